// File: rtl/twiddle_gen_pkg.sv
// Shared FFT constants and the quarter-wave cosine table generator.
package twiddle_gen_pkg;

  localparam int FFT_R = 5;
  localparam int FFT_N = 1 << FFT_R;
  localparam int FFT_W = 16;
  localparam int FFT_A = (1 << (FFT_W - 1)) - 1;

  localparam real PI = 3.14159265358979323846;

  // round(a*cos(2*pi*m/n)) for 0 <= m <= n/4; the angle never exceeds pi/2,
  // so a Taylor series evaluated at elaboration time is far below half an LSB.
  function automatic int calc_c(int m, int n, int a);
    real x, term, sum;
    x    = 2.0 * PI * $itor(m) / $itor(n);
    term = 1.0;
    sum  = 1.0;
    for (int i = 1; i <= 14; i++) begin
      term = -term * x * x / $itor((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    return $rtoi($itor(a) * sum + 0.5);
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM, two read ports, registered outputs.
module twiddle_qrom
  import twiddle_gen_pkg::*;
#(
  parameter int N  = FFT_N,
  parameter int W  = FFT_W,
  parameter int A  = FFT_A,
  parameter int AW = $clog2(N / 4 + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_en,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  output logic [W-1:0]  o_data_a,
  output logic [W-1:0]  o_data_b
);

  localparam int DEPTH = N / 4 + 1;

  logic [W-1:0] rom [DEPTH];

  for (genvar m = 0; m < DEPTH; m++) begin : g_rom
    localparam int CV = calc_c(m, N, A);
    assign rom[m] = W'(CV);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_data_a <= '0;
      o_data_b <= '0;
    end else if (i_en) begin
      o_data_a <= rom[i_addr_a];
      o_data_b <= rom[i_addr_b];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle factor generator: quadrant fold, two-stage valid/ready pipeline, sign application.
module twiddle_gen
  import twiddle_gen_pkg::*;
#(
  parameter int R = FFT_R,
  parameter int N = FFT_N,
  parameter int W = FFT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [R-2:0] i_exponent,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_re,
  output logic [W-1:0] o_im
);

  localparam int EW = R - 1;
  localparam int A  = (1 << (W - 1)) - 1;
  localparam logic [EW-1:0] QTR = EW'(N / 4);

  logic          adv1, adv2;
  logic          quad;
  logic [EW-1:0] low, addr_re_d, addr_im_d;
  logic          s1_valid, s1_quad;
  logic [EW-1:0] s1_addr_re, s1_addr_im;
  logic          s2_valid, s2_quad;
  logic [W-1:0]  mag_re, mag_im;

  always_comb begin
    adv2    = !s2_valid || i_ready;
    adv1    = !s1_valid || adv2;
    o_ready = adv1;
  end

  // Second quadrant swaps the roles of the two table addresses.
  always_comb begin
    quad      = i_exponent[EW-1];
    low       = {1'b0, i_exponent[EW-2:0]};
    addr_re_d = quad ? (QTR - low) : low;
    addr_im_d = quad ? low : (QTR - low);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_valid   <= 1'b0;
      s1_quad    <= 1'b0;
      s1_addr_re <= '0;
      s1_addr_im <= '0;
    end else if (adv1) begin
      s1_valid   <= i_valid;
      s1_quad    <= quad;
      s1_addr_re <= addr_re_d;
      s1_addr_im <= addr_im_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s2_valid <= 1'b0;
      s2_quad  <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      s2_quad  <= s1_quad;
    end
  end

  twiddle_qrom #(
    .N (N),
    .W (W),
    .A (A),
    .AW(EW)
  ) u_qrom (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (adv2),
    .i_addr_a(s1_addr_re),
    .i_addr_b(s1_addr_im),
    .o_data_a(mag_re),
    .o_data_b(mag_im)
  );

  // The imaginary part is always -sin, hence always the negated table value.
  always_comb begin
    o_valid = s2_valid;
    o_re    = s2_quad ? -mag_re : mag_re;
    o_im    = -mag_im;
  end

endmodule
